// File: rtl/pc_sequencer.sv
// pc_sequencer
//    Control sequencer for a tiny accumulator machine.  Each instruction is
//    walked through FETCH -> DECODE -> EXEC, one cycle each.  Opcode 4'hF
//    parks the machine in HALT, and only reset leaves that state.
//
// Ports
//    clk       single clock, all state updates on the rising edge
//    reset     synchronous, active-high; forces IDLE and clears retired
//    start     leaves IDLE for FETCH; ignored in every other state
//    pc_q      current program counter value
//    instr     instruction register contents, [7:4] opcode, [3:0] operand
//    zero      accumulator-zero flag from the ALU
//    pc_next   value loaded into the program counter every clock
//    mem_rd    program memory read strobe (addressed by pc_q)
//    ir_load   instruction register capture strobe
//    acc_load  accumulator write strobe
//    alu_sub   ALU subtract select, meaningful only while acc_load=1
//    out_load  output register write strobe
//    busy      high in FETCH, DECODE and EXEC
//    halted    high in HALT
//    retired   saturating count of executed instructions
module pc_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] pc_q,
   input  logic [7:0] instr,
   input  logic       zero,
   output logic [3:0] pc_next,
   output logic       mem_rd,
   output logic       ir_load,
   output logic       acc_load,
   output logic       alu_sub,
   output logic       out_load,
   output logic       busy,
   output logic       halted,
   output logic [7:0] retired
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_OUT = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [2:0] state_q, state_d;
   logic [7:0] retired_q, retired_d;

   logic [3:0] opcode;
   logic [3:0] operand;

   assign opcode  = instr[7:4];
   assign operand = instr[3:0];
   assign retired = retired_q;

   // Next-state logic.  start only matters in IDLE; HALT is a sink.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
         ST_EXEC:   state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Retired counter: one count per EXEC cycle, sticking at 255.
   // HLT never reaches EXEC, so it is never counted.
   always_comb begin
      retired_d = retired_q;
      if ((state_q == ST_EXEC) && (retired_q != 8'hFF))
         retired_d = retired_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         retired_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Output decode from the registered state only, so start never reaches
   // a strobe combinationally.  Reset overrides everything in its own cycle
   // so an instruction caught mid-EXEC issues no strobe.
   always_comb begin
      pc_next  = pc_q;
      mem_rd   = 1'b0;
      ir_load  = 1'b0;
      acc_load = 1'b0;
      alu_sub  = 1'b0;
      out_load = 1'b0;
      busy     = 1'b0;
      halted   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_rd  = 1'b1;
            ir_load = 1'b1;
            pc_next = pc_q + 4'd1;
            busy    = 1'b1;
         end
         ST_DECODE: begin
            busy = 1'b1;
         end
         ST_EXEC: begin
            busy = 1'b1;
            case (opcode)
               OP_LDA, OP_ADD: acc_load = 1'b1;
               OP_SUB: begin
                  acc_load = 1'b1;
                  alu_sub  = 1'b1;
               end
               OP_OUT: out_load = 1'b1;
               OP_JMP: pc_next = operand;
               OP_JZ:  if (zero) pc_next = operand;
               default: ;
            endcase
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         pc_next  = 4'd0;
         mem_rd   = 1'b0;
         ir_load  = 1'b0;
         acc_load = 1'b0;
         alu_sub  = 1'b0;
         out_load = 1'b0;
         busy     = 1'b0;
         halted   = 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//    Directed bench for pc_sequencer.  A table of per-cycle vectors walks a
//    short program through every opcode class, then hand-written sequences
//    cover reset during EXEC and saturation of the retired counter.
module tb_pc_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] pc_q;
   logic [7:0] instr;
   logic       zero;
   logic [3:0] pc_next;
   logic       mem_rd;
   logic       ir_load;
   logic       acc_load;
   logic       alu_sub;
   logic       out_load;
   logic       busy;
   logic       halted;
   logic [7:0] retired;

   int checks;
   int failures;

   pc_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pc_q     (pc_q),
      .instr    (instr),
      .zero     (zero),
      .pc_next  (pc_next),
      .mem_rd   (mem_rd),
      .ir_load  (ir_load),
      .acc_load (acc_load),
      .alu_sub  (alu_sub),
      .out_load (out_load),
      .busy     (busy),
      .halted   (halted),
      .retired  (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       st;
      logic [3:0] pc;
      logic [7:0] ins;
      logic       z;
      logic [3:0] e_pc;
      logic       e_mrd;
      logic       e_irl;
      logic       e_acc;
      logic       e_sub;
      logic       e_out;
      logic       e_busy;
      logic       e_halt;
      logic [7:0] e_ret;
   } vec_t;

   vec_t vecs[$];

   // Compare one observed value against its expected value.
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and let them settle so the
   // outputs can be sampled well away from the rising edge.
   task automatic applyStimulus(input logic r, input logic s, input logic [3:0] p,
                                input logic [7:0] i, input logic z);
      @(negedge clk);
      reset = r;
      start = s;
      pc_q  = p;
      instr = i;
      zero  = z;
      #1;
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      check({tag, ".pc_next"},  {4'd0, pc_next}, {4'd0, v.e_pc});
      check({tag, ".mem_rd"},   {7'd0, mem_rd},   {7'd0, v.e_mrd});
      check({tag, ".ir_load"},  {7'd0, ir_load},  {7'd0, v.e_irl});
      check({tag, ".acc_load"}, {7'd0, acc_load}, {7'd0, v.e_acc});
      check({tag, ".alu_sub"},  {7'd0, alu_sub},  {7'd0, v.e_sub});
      check({tag, ".out_load"}, {7'd0, out_load}, {7'd0, v.e_out});
      check({tag, ".busy"},     {7'd0, busy},     {7'd0, v.e_busy});
      check({tag, ".halted"},   {7'd0, halted},   {7'd0, v.e_halt});
      check({tag, ".retired"},  retired,          v.e_ret);
   endtask

   function automatic vec_t mk(input logic r, input logic s, input logic [3:0] p,
                               input logic [7:0] i, input logic z, input logic [3:0] epc,
                               input logic [7:0] strobes, input logic [7:0] eret);
      // strobes = {mem_rd, ir_load, acc_load, alu_sub, out_load, busy, halted, unused}
      vec_t v;
      v.rst = r; v.st = s; v.pc = p; v.ins = i; v.z = z;
      v.e_pc   = epc;
      v.e_mrd  = strobes[7];
      v.e_irl  = strobes[6];
      v.e_acc  = strobes[5];
      v.e_sub  = strobes[4];
      v.e_out  = strobes[3];
      v.e_busy = strobes[2];
      v.e_halt = strobes[1];
      v.e_ret  = eret;
      return v;
   endfunction

   localparam logic [7:0] S_NONE  = 8'b0000_0000;
   localparam logic [7:0] S_FETCH = 8'b1100_0100;
   localparam logic [7:0] S_BUSY  = 8'b0000_0100;
   localparam logic [7:0] S_ACC   = 8'b0010_0100;
   localparam logic [7:0] S_SUB   = 8'b0011_0100;
   localparam logic [7:0] S_OUT   = 8'b0000_1100;
   localparam logic [7:0] S_HALT  = 8'b0000_0010;

   initial begin
      vec_t v;
      int prev_ret;
      int monotonic_ok;
      checks   = 0;
      failures = 0;
      reset = 1'b1; start = 1'b0; pc_q = 4'd0; instr = 8'h00; zero = 1'b0;

      //           rst st  pc    ins    z   pc_next strobes  retired
      vecs.push_back(mk(1, 1, 4'd5,  8'h12, 1, 4'd0,  S_NONE,  8'd0)); // reset beats start
      vecs.push_back(mk(0, 0, 4'd0,  8'h00, 0, 4'd0,  S_NONE,  8'd0)); // IDLE
      vecs.push_back(mk(0, 1, 4'd0,  8'h00, 0, 4'd0,  S_NONE,  8'd0)); // IDLE, start
      vecs.push_back(mk(0, 0, 4'd0,  8'h00, 0, 4'd1,  S_FETCH, 8'd0)); // FETCH
      vecs.push_back(mk(0, 0, 4'd1,  8'h00, 0, 4'd1,  S_BUSY,  8'd0)); // DECODE
      vecs.push_back(mk(0, 0, 4'd1,  8'h00, 0, 4'd1,  S_BUSY,  8'd0)); // EXEC NOP
      vecs.push_back(mk(0, 0, 4'd1,  8'h00, 0, 4'd2,  S_FETCH, 8'd1)); // FETCH again
      vecs.push_back(mk(0, 0, 4'd2,  8'h15, 0, 4'd2,  S_BUSY,  8'd1)); // DECODE LDA
      vecs.push_back(mk(0, 1, 4'd2,  8'h15, 0, 4'd2,  S_ACC,   8'd1)); // EXEC LDA, start ignored
      vecs.push_back(mk(0, 0, 4'd2,  8'h15, 0, 4'd3,  S_FETCH, 8'd2));
      vecs.push_back(mk(0, 0, 4'd3,  8'h27, 0, 4'd3,  S_BUSY,  8'd2)); // DECODE ADD
      vecs.push_back(mk(0, 0, 4'd3,  8'h27, 0, 4'd3,  S_ACC,   8'd2)); // EXEC ADD
      vecs.push_back(mk(0, 0, 4'd3,  8'h27, 0, 4'd4,  S_FETCH, 8'd3));
      vecs.push_back(mk(0, 0, 4'd4,  8'h38, 1, 4'd4,  S_BUSY,  8'd3)); // DECODE SUB
      vecs.push_back(mk(0, 0, 4'd4,  8'h38, 1, 4'd4,  S_SUB,   8'd3)); // EXEC SUB
      vecs.push_back(mk(0, 0, 4'd4,  8'h38, 0, 4'd5,  S_FETCH, 8'd4));
      vecs.push_back(mk(0, 0, 4'd5,  8'h40, 0, 4'd5,  S_BUSY,  8'd4)); // DECODE OUT
      vecs.push_back(mk(0, 0, 4'd5,  8'h40, 0, 4'd5,  S_OUT,   8'd4)); // EXEC OUT
      vecs.push_back(mk(0, 0, 4'd15, 8'h40, 0, 4'd0,  S_FETCH, 8'd5)); // PC wrap 15 -> 0
      vecs.push_back(mk(0, 0, 4'd0,  8'h59, 0, 4'd0,  S_BUSY,  8'd5)); // DECODE JMP 9
      vecs.push_back(mk(0, 0, 4'd0,  8'h59, 0, 4'd9,  S_BUSY,  8'd5)); // EXEC JMP
      vecs.push_back(mk(0, 0, 4'd9,  8'h59, 0, 4'd10, S_FETCH, 8'd6));
      vecs.push_back(mk(0, 0, 4'd10, 8'h63, 0, 4'd10, S_BUSY,  8'd6)); // DECODE JZ 3
      vecs.push_back(mk(0, 0, 4'd10, 8'h63, 0, 4'd10, S_BUSY,  8'd6)); // EXEC JZ not taken
      vecs.push_back(mk(0, 0, 4'd10, 8'h63, 1, 4'd11, S_FETCH, 8'd7));
      vecs.push_back(mk(0, 0, 4'd11, 8'h63, 1, 4'd11, S_BUSY,  8'd7)); // DECODE JZ, zero=1
      vecs.push_back(mk(0, 0, 4'd11, 8'h63, 1, 4'd3,  S_BUSY,  8'd7)); // EXEC JZ taken
      vecs.push_back(mk(0, 0, 4'd3,  8'h7A, 0, 4'd4,  S_FETCH, 8'd8));
      vecs.push_back(mk(0, 0, 4'd4,  8'h7A, 0, 4'd4,  S_BUSY,  8'd8)); // DECODE op 7
      vecs.push_back(mk(0, 0, 4'd4,  8'h7A, 1, 4'd4,  S_BUSY,  8'd8)); // EXEC op 7 = NOP
      vecs.push_back(mk(0, 0, 4'd4,  8'hF0, 0, 4'd5,  S_FETCH, 8'd9));
      vecs.push_back(mk(0, 0, 4'd5,  8'hF0, 0, 4'd5,  S_BUSY,  8'd9)); // DECODE HLT
      vecs.push_back(mk(0, 0, 4'd5,  8'hF0, 0, 4'd5,  S_HALT,  8'd9)); // HALT, not counted
      vecs.push_back(mk(0, 1, 4'd5,  8'hF0, 0, 4'd5,  S_HALT,  8'd9)); // start ignored
      vecs.push_back(mk(0, 0, 4'd7,  8'h12, 0, 4'd7,  S_HALT,  8'd9)); // still HALT
      vecs.push_back(mk(1, 0, 4'd7,  8'h12, 0, 4'd0,  S_NONE,  8'd9)); // reset in HALT
      vecs.push_back(mk(0, 0, 4'd7,  8'h12, 0, 4'd7,  S_NONE,  8'd0)); // back in IDLE

      // Two reset cycles so retired is defined before the table starts.
      repeat (2) @(posedge clk);

      for (int k = 0; k < vecs.size(); k++) begin
         v = vecs[k];
         applyStimulus(v.rst, v.st, v.pc, v.ins, v.z);
         checkOutput($sformatf("vec%0d", k), v);
      end

      // Reset arriving during EXEC of an ADD: no acc_load, back to IDLE.
      applyStimulus(0, 1, 4'd0, 8'h00, 0);                     // IDLE + start
      applyStimulus(0, 0, 4'd0, 8'h00, 0);                     // FETCH
      applyStimulus(0, 0, 4'd1, 8'h00, 0);                     // DECODE NOP
      applyStimulus(0, 0, 4'd1, 8'h00, 0);                     // EXEC NOP
      applyStimulus(0, 0, 4'd1, 8'h00, 0);                     // FETCH
      check("rst_exec.pre_retired", retired, 8'd1);
      applyStimulus(0, 0, 4'd2, 8'h21, 0);                     // DECODE ADD
      applyStimulus(1, 0, 4'd2, 8'h21, 0);                     // EXEC ADD with reset
      check("rst_exec.acc_load", {7'd0, acc_load}, 8'd0);
      check("rst_exec.pc_next",  {4'd0, pc_next},  8'd0);
      check("rst_exec.busy",     {7'd0, busy},     8'd0);
      applyStimulus(0, 0, 4'd6, 8'h21, 0);                     // should be IDLE
      check("rst_exec.retired",  retired,          8'd0);
      check("rst_exec.idle_pc",  {4'd0, pc_next},  8'd6);
      check("rst_exec.idle_busy", {7'd0, busy},    8'd0);
      check("rst_exec.idle_mrd", {7'd0, mem_rd},   8'd0);

      // 300 NOPs: retired must climb to 255 and stay there.
      applyStimulus(0, 1, 4'd0, 8'h00, 0);                     // IDLE + start
      prev_ret = 0;
      monotonic_ok = 1;
      for (int n = 0; n < 300; n++) begin
         applyStimulus(0, 0, 4'd0, 8'h00, 0);                  // FETCH
         if (n == 255) check("sat.at255", retired, 8'd255);
         if (n == 254) check("sat.at254", retired, 8'd254);
         if (int'(retired) < prev_ret) monotonic_ok = 0;
         prev_ret = int'(retired);
         applyStimulus(0, 0, 4'd1, 8'h00, 0);                  // DECODE
         applyStimulus(0, 0, 4'd1, 8'h00, 0);                  // EXEC
      end
      applyStimulus(0, 0, 4'd1, 8'h00, 0);                     // FETCH after 300th
      check("sat.final", retired, 8'd255);
      check("sat.final_fetch", {7'd0, mem_rd}, 8'd1);
      check("sat.no_wrap", monotonic_ok[7:0], 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
